// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus types for the fetch/memory-stage arbiter and its neighbours.
package dbus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam int unsigned STARVE_LIMIT_DEF = 8;
  localparam int unsigned CNT_W_DEF        = 4;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    msize_t            size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  // Arbiter states kept as plain encoded constants for legacy tooling.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_GRANT_I = 2'd1;
  localparam arb_state_t ST_GRANT_D = 2'd2;

  // A downstream transaction is finished only when both handshakes land together.
  function automatic logic resp_done(input dbus_resp_t r);
    return r.addr_ok & r.data_ok;
  endfunction

endpackage

// File: rtl/dbus_arbiter_if.sv
// Bundle of the two upstream requesters, the downstream port and arbiter status.
interface dbus_arbiter_if;
  import dbus_arbiter_pkg::*;

  dbus_req_t  ireq;
  dbus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  oreq;
  dbus_resp_t oresp;
  logic       busy;
  logic       grant_d;

  // Arbiter side.
  modport slave (
    input  ireq, dreq, oresp,
    output iresp, dresp, oreq, busy, grant_d
  );

  // Environment side: requesters plus downstream memory.
  modport master (
    output ireq, dreq, oresp,
    input  iresp, dresp, oreq, busy, grant_d
  );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-way data-bus arbiter: memory stage (D) wins by default, fetch (I) wins
// after STARVE_LIMIT consecutive D grants taken while it was waiting.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  dbus_arbiter_if.slave dbus
);

  if ((64'd1 << CNT_W) <= 64'(STARVE_LIMIT)) begin : g_bad_cfg
    $error("dbus_arbiter: CNT_W too narrow for STARVE_LIMIT");
  end

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dbus_req_t        oreq_q, oreq_d;
  logic             done_c;
  logic             i_starved_c;

  assign done_c      = resp_done(dbus.oresp);
  assign i_starved_c = dbus.ireq.valid && (cnt_q == LIMIT);

  // Next-state, request latch and starvation counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oreq_d  = oreq_q;
    case (state_q)
      ST_IDLE: begin
        if (dbus.dreq.valid && !i_starved_c) begin
          state_d      = ST_GRANT_D;
          oreq_d       = dbus.dreq;
          oreq_d.valid = 1'b1;
          if (dbus.ireq.valid) begin
            cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end else if (dbus.ireq.valid) begin
          state_d       = ST_GRANT_I;
          oreq_d        = dbus.ireq;
          oreq_d.valid  = 1'b1;
          oreq_d.strobe = '0;
          cnt_d         = '0;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (done_c) begin
          state_d      = ST_IDLE;
          oreq_d.valid = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        oreq_d.valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      oreq_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oreq_q  <= oreq_d;
    end
  end

  assign dbus.oreq    = oreq_q;
  assign dbus.busy    = (state_q != ST_IDLE);
  assign dbus.grant_d = (state_q == ST_GRANT_D);

  // A requester that withdrew mid-grant (flush) sees nothing of its response.
  assign dbus.iresp = ((state_q == ST_GRANT_I) && dbus.ireq.valid) ? dbus.oresp : '0;
  assign dbus.dresp = ((state_q == ST_GRANT_D) && dbus.dreq.valid) ? dbus.oresp : '0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: predicted grants are queued as requests
// are driven and checked as the downstream port shows each transaction.
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic        exp_resp;
    int          n_aok;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  dbus_arbiter_if bus();

  dbus_arbiter #(.STARVE_LIMIT(2), .CNT_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .dbus (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cmpl_cnt = 0;
  int   lat = 3;
  int   ao = 0;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_data(input logic [31:0] a);
    return {a, ~a};
  endfunction

  function automatic dbus_req_t mk_req(input logic v, input logic [31:0] a, input msize_t s,
                                       input logic [7:0] st, input logic [63:0] d);
    dbus_req_t r;
    r.valid = v; r.addr = a; r.size = s; r.strobe = st; r.data = d;
    return r;
  endfunction

  // Downstream memory: completes `lat` cycles after oreq.valid, with `ao`
  // addr_ok-only cycles just before completion.
  initial begin
    int k;
    k = 0;
    bus.oresp = '0;
    forever begin
      @(posedge clk); #1;
      bus.oresp = '0;
      if (rst || !bus.oreq.valid) begin
        k = 0;
      end else begin
        if (k == lat) begin
          bus.oresp.addr_ok = 1'b1;
          bus.oresp.data_ok = 1'b1;
          bus.oresp.data    = mem_data(bus.oreq.addr);
        end else if (k >= lat - ao) begin
          bus.oresp.addr_ok = 1'b1;
        end
        k++;
      end
    end
  end

  // Monitor: pops a prediction per grant and checks every granted cycle.
  initial begin
    exp_t       cur;
    logic       prev_v;
    logic       active;
    int         nd, na;
    dbus_resp_t gr, ot;
    prev_v = 1'b0; active = 1'b0; nd = 0; na = 0;
    cur = '{1'b0, 32'h0, 8'h0, 1'b0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0; active = 1'b0;
      end else begin
        if (bus.oreq.valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", 128'(1), 128'(0));
            active = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            active = 1'b1;
            nd = 0; na = 0;
            chk("grant_d", 128'(bus.grant_d), 128'(cur.is_d));
            chk("oreq_addr", 128'(bus.oreq.addr), 128'(cur.addr));
            chk("oreq_strobe", 128'(bus.oreq.strobe), 128'(cur.strobe));
            chk("busy_grant", 128'(bus.busy), 128'(1));
          end
        end
        if (bus.oreq.valid && active) begin
          gr = cur.is_d ? bus.dresp : bus.iresp;
          ot = cur.is_d ? bus.iresp : bus.dresp;
          chk("other_resp_zero", 128'(ot), 128'(0));
          if (!cur.exp_resp) begin
            chk("flushed_resp_zero", 128'(gr), 128'(0));
          end else begin
            if (gr.addr_ok) na++;
            if (gr.data_ok) begin
              nd++;
              chk("rdata", 128'(gr.data), 128'(mem_data(cur.addr)));
            end
          end
        end
        if (bus.oreq.valid && bus.oresp.addr_ok && bus.oresp.data_ok) cmpl_cnt++;
        if (!bus.oreq.valid && prev_v && active) begin
          if (cur.exp_resp) begin
            chk("n_data_ok", 128'(nd), 128'(1));
            chk("n_addr_ok", 128'(na), 128'(cur.n_aok));
          end
          chk("busy_after_done", 128'(bus.busy), 128'(0));
          active = 1'b0;
        end
        prev_v = bus.oreq.valid;
      end
    end
  end

  task automatic wait_valid(input int max);
    int n;
    n = 0;
    while (!bus.oreq.valid && n < max) begin
      @(negedge clk); n++;
    end
    chk("oreq_valid_timeout", 128'(bus.oreq.valid), 128'(1));
  endtask

  task automatic wait_cmpl(input int target, input int max);
    int n;
    n = 0;
    while (cmpl_cnt < target && n < max) begin
      @(negedge clk); #1; n++;
    end
    chk("cmpl_timeout", 128'(cmpl_cnt >= target), 128'(1));
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.ireq = '0;
    bus.dreq = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_grant_d", 128'(bus.grant_d), 128'(0));
    chk("rst_oreq", 128'(bus.oreq), 128'(0));
    chk("rst_iresp", 128'(bus.iresp), 128'(0));
    chk("rst_dresp", 128'(bus.dresp), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // D alone, 3-cycle downstream latency.
    lat = 3; ao = 0;
    base = cmpl_cnt;
    exp_q.push_back('{1'b1, 32'h8000_0010, 8'h0F, 1'b1, 1});
    bus.dreq = mk_req(1'b1, 32'h8000_0010, MSIZE8, 8'h0F, 64'h1122_3344_5566_7788);
    @(negedge clk);
    chk("lat_before_sample", 128'(bus.oreq.valid), 128'(0));
    @(negedge clk);
    chk("lat_one_cycle", 128'(bus.oreq.valid), 128'(1));
    chk("oreq_size", 128'(bus.oreq.size), 128'(MSIZE8));
    wait_cmpl(base + 1, 20);
    @(posedge clk); #1;
    bus.dreq.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Contention with limit 2: D, D, I, D, D, I; fetch strobe forced to 0.
    lat = 2;
    base = cmpl_cnt;
    for (int g = 0; g < 6; g++) begin
      if (g % 3 == 2) exp_q.push_back('{1'b0, 32'h0000_2000, 8'h00, 1'b1, 1});
      else            exp_q.push_back('{1'b1, 32'h0000_1000, 8'hF0, 1'b1, 1});
    end
    bus.ireq = mk_req(1'b1, 32'h0000_2000, MSIZE4, 8'hFF, 64'hDEAD_BEEF);
    bus.dreq = mk_req(1'b1, 32'h0000_1000, MSIZE4, 8'hF0, 64'hCAFE_F00D);
    wait_cmpl(base + 6, 80);
    @(posedge clk); #1;
    bus.ireq.valid = 1'b0;
    bus.dreq.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // D withdraws mid-grant: transaction still runs to completion, no response.
    lat = 4;
    base = cmpl_cnt;
    exp_q.push_back('{1'b1, 32'h0000_3000, 8'hFF, 1'b0, 0});
    bus.dreq = mk_req(1'b1, 32'h0000_3000, MSIZE8, 8'hFF, 64'h0);
    wait_valid(10);
    @(posedge clk); #1;
    bus.dreq.valid = 1'b0;
    bus.dreq.addr  = 32'h0000_3FF0;
    #1;
    chk("flush_oreq_held", 128'(bus.oreq.valid), 128'(1));
    chk("flush_addr_stable", 128'(bus.oreq.addr), 128'(32'h0000_3000));
    wait_cmpl(base + 1, 20);
    repeat (2) @(posedge clk);
    #1;
    chk("flush_idle", 128'(bus.busy), 128'(0));

    // addr_ok alone for 2 cycles, then full completion.
    lat = 3; ao = 2;
    base = cmpl_cnt;
    exp_q.push_back('{1'b1, 32'h0000_4008, 8'h01, 1'b1, 3});
    bus.dreq = mk_req(1'b1, 32'h0000_4008, MSIZE1, 8'h01, 64'h5A);
    wait_valid(10);
    @(negedge clk); @(negedge clk);
    chk("aok_grant_held", 128'(bus.busy), 128'(1));
    wait_cmpl(base + 1, 20);
    @(posedge clk); #1;
    bus.dreq.valid = 1'b0;
    ao = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset two cycles into a fetch grant.
    lat = 8;
    exp_q.push_back('{1'b0, 32'h0000_5000, 8'h00, 1'b1, 1});
    bus.ireq = mk_req(1'b1, 32'h0000_5000, MSIZE4, 8'hFF, 64'h0);
    wait_valid(10);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    bus.ireq.valid = 1'b0;
    #1;
    chk("rst_mid_busy", 128'(bus.busy), 128'(0));
    chk("rst_mid_valid", 128'(bus.oreq.valid), 128'(0));
    chk("rst_mid_grant_d", 128'(bus.grant_d), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_oreq", 128'(bus.oreq), 128'(0));
    chk("post_rst_busy", 128'(bus.busy), 128'(0));

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single downstream data-memory port between two requesters: instruction fetch (I) and the memory stage (D).
- Sits between the core pipeline and the cache/bus bridge.
- Grants one transaction at a time and holds the grant until the transaction completes.
- D has priority, with an anti-starvation override for I.

Parameters:
- STARVE_LIMIT, 8: consecutive D grants taken while I was waiting, after which I wins the next contested arbitration.
- CNT_W, 4: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ireq  in  dbus_req_t  fetch request; strobe/data ignored.
- iresp  out  dbus_resp_t  fetch response.
- dreq  in  dbus_req_t  memory-stage request.
- dresp  out  dbus_resp_t  memory-stage response.
- oreq  out  dbus_req_t  request to downstream memory.
- oresp  in  dbus_resp_t  downstream response.
- busy  out  1  high while a grant is outstanding.
- grant_d  out  1  high while the outstanding grant belongs to D.

Behaviour:
- State enum arb_state_t: IDLE, GRANT_I, GRANT_D.
- Reset: state=IDLE, starvation counter=0, oreq all fields 0, busy=0, grant_d=0. iresp/dresp read 0 because they are gated by state.
- Completion of a transaction is defined as oresp.addr_ok & oresp.data_ok in the same cycle.
- IDLE arbitration (registered decision):
  - If dreq.valid and not (ireq.valid and cnt==STARVE_LIMIT): next state GRANT_D, latch dreq into oreq.
  - Else if ireq.valid: next state GRANT_I, latch ireq into oreq with strobe forced to 0.
  - Else: stay in IDLE.
- Latency: oreq.valid rises on the cycle after the requester's valid is sampled in IDLE. Minimum round trip is 1 arbitration cycle plus downstream latency.
- GRANT_x:
  - oreq holds its latched value, valid=1.
  - The granted requester's resp is oresp passed through combinationally. The other requester's resp is all zeros.
  - On completion: oreq.valid<=0 and next state is IDLE. There is one idle bubble cycle before the next grant; no back-to-back re-grant.
- Starvation counter, updated on the IDLE->GRANT_D edge:
  - If ireq.valid: cnt<=min(cnt+1, STARVE_LIMIT); else cnt<=0.
  - On the IDLE->GRANT_I edge: cnt<=0.
- Requester withdraws valid mid-grant (pipeline flush): the downstream transaction cannot be aborted. The arbiter keeps oreq stable until completion. The completion pulse is forwarded only if the requester's valid is still high that cycle; otherwise it is dropped.
- Requests are not re-sampled during a grant. A changed addr/data from the granted requester is ignored until the next IDLE.
- Simultaneous ireq.valid & dreq.valid in IDLE resolves per the priority rule above; the loser waits.
- oresp with addr_ok only (no data_ok): forwarded to the granted requester, but the state is held.
- oresp activity while IDLE: ignored, not forwarded.
- Reset asserted mid-grant: immediate return to IDLE, oreq.valid=0, counter cleared. The downstream side must tolerate request withdrawal on reset.
- busy = (state != IDLE); grant_d = (state == GRANT_D). Both are derived from registered state only.

Decomposition:
- Shared package common: dbus_req_t and dbus_resp_t (existing); add arb_state_t enum and STARVE_LIMIT default constant.
- No sub-module: arbitration FSM, request latch and counter fit in one module.

Test Plan:
- Only dreq.valid, addr=0x8000_0010, size=MSIZE8; downstream completes 3 cycles after oreq.valid -> oreq.valid rises 1 cycle after dreq.valid, dresp.data_ok pulses once with the data, iresp stays 0, busy falls the cycle after completion.
- ireq and dreq both valid from reset, STARVE_LIMIT=2, dreq re-issued every IDLE -> grant order D, D, I, D, D, I; cnt resets to 0 after each I grant.
- Fetch grant with ireq.strobe=0xFF -> oreq.strobe=0.
- During GRANT_D, dreq.valid dropped before completion -> oreq stays valid until addr_ok&data_ok, dresp stays all-zero, FSM returns to IDLE.
- rst asserted 2 cycles into GRANT_I -> same cycle: state=IDLE, oreq.valid=0, busy=0; after release with no requests, oreq stays 0.
- Downstream asserts addr_ok alone for 2 cycles, then addr_ok&data_ok -> grant held throughout, exactly one completion cycle seen by the requester.
